// File: rtl/adc_packer.sv
// adc_packer
//   Gathers bytes from NCH per-channel byte FIFOs into one framed byte stream.
//   Frame layout: 0x55 0xAA dev_info dev_smpr, then NWORD bytes from each
//   enabled channel in ascending channel order, then an optional sum byte.
//
// Optional feature macro: ADC_PACKER_CHECKSUM_EN
//   defined   -> a SUM state appends the 8-bit sum of every frame byte after
//                0x55 0xAA
//   undefined -> DRAIN goes straight to DONE
//
// Parameters:
//   NCH    number of channel FIFOs (1..16)
//   NWORD  bytes read per enabled channel per frame (1..255)
//   TOUT   consecutive empty cycles tolerated before the frame is aborted
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   fs_fifo       frame start request (level, held until fd_fifo seen)
//   fd_fifo       frame done, high in DONE until fs_fifo drops
//   chn_mask      channel enables, latched at frame start
//   dev_info      header byte 3, latched at frame start
//   dev_smpr      header byte 4, latched at frame start
//   fifoi_grxen   one-hot read strobe to the channel FIFOs
//   fifoi_grxd    channel i data on [8i+7:8i], valid one cycle after strobe
//   fifoi_gempty  per-channel empty flags
//   adc_rxen      output byte valid
//   adc_rxd       output byte (holds its value while adc_rxen is low)
//   err           sticky stall-timeout flag, cleared only by reset
module adc_packer #(
    parameter int NCH   = 8,
    parameter int NWORD = 32,
    parameter int TOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs_fifo,
    output logic             fd_fifo,
    input  logic [NCH-1:0]   chn_mask,
    input  logic [7:0]       dev_info,
    input  logic [7:0]       dev_smpr,
    output logic [NCH-1:0]   fifoi_grxen,
    input  logic [8*NCH-1:0] fifoi_grxd,
    input  logic [NCH-1:0]   fifoi_gempty,
    output logic             adc_rxen,
    output logic [7:0]       adc_rxd,
    output logic             err
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = $clog2(TOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        READ,
        DRAIN,
`ifdef ADC_PACKER_CHECKSUM_EN
        SUM,
`endif
        DONE
    } state_t;

    state_t         state_q;
    logic [NCH-1:0] mask_q;
    logic [7:0]     info_q;
    logic [7:0]     smpr_q;
    logic [1:0]     hcnt_q;
    logic [CW-1:0]  ch_q;
    logic [7:0]     wcnt_q;
    logic [SW-1:0]  stall_q;
    logic           pend_q;
    logic [CW-1:0]  pend_ch_q;
`ifdef ADC_PACKER_CHECKSUM_EN
    logic [7:0]     sum_q;
`endif

    // Lowest enabled channel at or above 'start'; MSB flags that one exists.
    function automatic logic [CW:0] first_from(input logic [NCH-1:0] m, input int start);
        logic [CW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= start && m[i]) r = {1'b1, CW'(i)};
        end
        return r;
    endfunction

    logic [CW:0] first_ch;
    logic [CW:0] next_ch;
    logic        last_word;
    logic        rd_strobe;
    logic [7:0]  rd_byte;

    assign first_ch  = first_from(mask_q, 0);
    assign next_ch   = first_from(mask_q, int'(ch_q) + 1);
    assign last_word = (wcnt_q == 8'(NWORD - 1));
    assign rd_byte   = fifoi_grxd[8*int'(pend_ch_q) +: 8];

    // The strobe must look at the empty flag of the same cycle, otherwise a
    // back-to-back read could hit a FIFO that its previous read just emptied,
    // so this is the one output decoded from state rather than registered.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        fifoi_grxen = '0;
        rd_strobe   = (state_q == READ) && !fifoi_gempty[ch_q];
        if (rd_strobe) fifoi_grxen[ch_q] = 1'b1;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            info_q    <= '0;
            smpr_q    <= '0;
            hcnt_q    <= '0;
            ch_q      <= '0;
            wcnt_q    <= '0;
            stall_q   <= '0;
            pend_q    <= 1'b0;
            pend_ch_q <= '0;
`ifdef ADC_PACKER_CHECKSUM_EN
            sum_q     <= '0;
`endif
            adc_rxen  <= 1'b0;
            adc_rxd   <= 8'h00;
            fd_fifo   <= 1'b0;
            err       <= 1'b0;
        end else begin
            adc_rxen <= 1'b0;

            // Read pipeline: strobe in cycle t, FIFO data valid in t+1,
            // byte registered onto adc_rxd for cycle t+2.
            pend_q    <= rd_strobe;
            pend_ch_q <= ch_q;
            if (pend_q) begin
                adc_rxen <= 1'b1;
                adc_rxd  <= rd_byte;
`ifdef ADC_PACKER_CHECKSUM_EN
                sum_q    <= sum_q + rd_byte;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (fs_fifo && !fd_fifo) begin
                        mask_q   <= chn_mask;
                        info_q   <= dev_info;
                        smpr_q   <= dev_smpr;
                        hcnt_q   <= 2'd1;
                        wcnt_q   <= '0;
                        stall_q  <= '0;
`ifdef ADC_PACKER_CHECKSUM_EN
                        sum_q    <= '0;
`endif
                        adc_rxen <= 1'b1;
                        adc_rxd  <= 8'h55;
                        state_q  <= HEAD;
                    end
                end

                HEAD: begin
                    adc_rxen <= 1'b1;
                    hcnt_q   <= hcnt_q + 2'd1;
                    case (hcnt_q)
                        2'd1: adc_rxd <= 8'hAA;
                        2'd2: begin
                            adc_rxd <= info_q;
`ifdef ADC_PACKER_CHECKSUM_EN
                            sum_q   <= sum_q + info_q;
`endif
                        end
                        default: begin
                            adc_rxd <= smpr_q;
`ifdef ADC_PACKER_CHECKSUM_EN
                            sum_q   <= sum_q + smpr_q;
`endif
                            if (first_ch[CW]) begin
                                ch_q    <= first_ch[CW-1:0];
                                state_q <= READ;
                            end else begin
`ifdef ADC_PACKER_CHECKSUM_EN
                                state_q <= SUM;
`else
                                state_q <= DONE;
                                fd_fifo <= 1'b1;
`endif
                            end
                        end
                    endcase
                end

                READ: begin
                    if (rd_strobe) begin
                        stall_q <= '0;
                        if (last_word) begin
                            wcnt_q <= '0;
                            if (next_ch[CW]) ch_q <= next_ch[CW-1:0];
                            else             state_q <= DRAIN;
                        end else begin
                            wcnt_q <= wcnt_q + 8'd1;
                        end
                    end else if (stall_q == SW'(TOUT - 1)) begin
                        // TOUT consecutive empty cycles: abandon the data phase.
                        err     <= 1'b1;
                        state_q <= DRAIN;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end

                // The pipeline is one read deep, so the last in-flight byte is
                // captured on the edge that leaves this state.
                DRAIN: begin
`ifdef ADC_PACKER_CHECKSUM_EN
                    state_q <= SUM;
`else
                    state_q <= DONE;
                    fd_fifo <= 1'b1;
`endif
                end

`ifdef ADC_PACKER_CHECKSUM_EN
                SUM: begin
                    adc_rxen <= 1'b1;
                    adc_rxd  <= sum_q;
                    state_q  <= DONE;
                    fd_fifo  <= 1'b1;
                end
`endif

                DONE: begin
                    if (!fs_fifo) begin
                        fd_fifo <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_packer.sv
// Self-checking bench for adc_packer (NCH=8, NWORD=4, TOUT=16).
// FIFOs are modelled as ramp sources with an availability count and optional
// empty injection; expected frames are built from the framing rules and
// checked by a negedge monitor that pops a scoreboard queue.
module tb_adc_packer;
    localparam int NCH   = 8;
    localparam int NWORD = 4;
    localparam int TOUT  = 16;
    localparam int BIG   = 1 << 30;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             fs_fifo = 1'b0;
    logic             fd_fifo;
    logic [NCH-1:0]   chn_mask = '0;
    logic [7:0]       dev_info = '0;
    logic [7:0]       dev_smpr = '0;
    logic [NCH-1:0]   fifoi_grxen;
    logic [8*NCH-1:0] fifoi_grxd;
    logic [NCH-1:0]   fifoi_gempty;
    logic             adc_rxen;
    logic [7:0]       adc_rxd;
    logic             err;

    always #5 clk = ~clk;

    adc_packer #(.NCH(NCH), .NWORD(NWORD), .TOUT(TOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .fs_fifo      (fs_fifo),
        .fd_fifo      (fd_fifo),
        .chn_mask     (chn_mask),
        .dev_info     (dev_info),
        .dev_smpr     (dev_smpr),
        .fifoi_grxen  (fifoi_grxen),
        .fifoi_grxd   (fifoi_grxd),
        .fifoi_gempty (fifoi_gempty),
        .adc_rxen     (adc_rxen),
        .adc_rxd      (adc_rxd),
        .err          (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [7:0] val;
        bit         is_data;
        bit         is_sum;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];
    int   strobe_log[$];
    int   rx_data_cyc[$];
    int   last_rx_cyc  = 0;
    int   err_rise_cyc = -1;
    bit   err_prev     = 1'b0;
    bit   err_sticky   = 1'b0;
    int   cyc          = 0;

    task automatic push(input logic [7:0] v, input bit d, input bit s);
        exp_t e;
        e.val = v; e.is_data = d; e.is_sum = s;
        exp_q.push_back(e);
    endtask

    // ---------------- FIFO model ----------------
    logic [7:0] cfg_nxt   [NCH];
    int         cfg_avail [NCH];
    bit         cfg_rnd    = 1'b0;
    bit         cfg_stall7 = 1'b0;
    int         cfg_seq    = 0;

    int               seen_seq = 0;
    logic [7:0]       nxt     [NCH];
    int               avail   [NCH];
    int               run_len [NCH];
    logic [NCH-1:0]   blk = '0;
    int               reads7 = 0;
    int               stall7_left = 0;
    logic [8*NCH-1:0] grxd_q = '0;

    assign fifoi_grxd = grxd_q;

    always_comb begin
        for (int i = 0; i < NCH; i++)
            fifoi_gempty[i] = (avail[i] == 0) || blk[i] || (i == 7 && stall7_left > 0);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cfg_seq != seen_seq) begin
            seen_seq <= cfg_seq;
            for (int i = 0; i < NCH; i++) begin
                nxt[i]     <= cfg_nxt[i];
                avail[i]   <= cfg_avail[i];
                run_len[i] <= 0;
            end
            blk         <= '0;
            reads7      <= 0;
            stall7_left <= 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (fifoi_grxen[i]) begin
                    grxd_q[8*i +: 8] <= nxt[i];
                    nxt[i]           <= nxt[i] + 8'd1;
                    if (avail[i] > 0) avail[i] <= avail[i] - 1;
                end
                if (cfg_rnd && run_len[i] < 6 && $urandom_range(3) == 0) begin
                    blk[i]     <= 1'b1;
                    run_len[i] <= run_len[i] + 1;
                end else begin
                    blk[i]     <= 1'b0;
                    run_len[i] <= 0;
                end
            end
            if (stall7_left > 0) stall7_left <= stall7_left - 1;
            else if (cfg_stall7 && fifoi_grxen[7]) begin
                if (reads7 == 1) stall7_left <= 10;
                reads7 <= reads7 + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        int   t;
        if (fifoi_grxen != '0) begin
            check("strobe_onehot", $countones(fifoi_grxen), 1);
            check("strobe_on_empty", |(fifoi_grxen & fifoi_gempty), 0);
            lat_q.push_back(cyc);
            strobe_log.push_back(cyc);
        end
        if (adc_rxen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_byte actual=%0h expected=none", adc_rxd);
            end else begin
                e = exp_q.pop_front();
                check("rx_byte", adc_rxd, e.val);
                if (e.is_data) begin
                    if (lat_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rx_latency actual=no_strobe expected=2");
                    end else begin
                        t = lat_q.pop_front();
                        check("rx_latency", cyc - t, 2);
                    end
                    rx_data_cyc.push_back(cyc);
                end
                if (e.is_sum) check("sum_timing", cyc - last_rx_cyc, 1);
            end
            last_rx_cyc = cyc;
        end
        if (err && !err_prev) err_rise_cyc = cyc;
        err_prev = err;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_fifos(input bit rnd_data, input int avail0, input bit rnd_stall, input bit st7);
        for (int i = 0; i < NCH; i++) begin
            cfg_nxt[i]   = rnd_data ? 8'($urandom) : 8'h00;
            cfg_avail[i] = (i == 0 && avail0 >= 0) ? avail0 : BIG;
        end
        cfg_rnd    = rnd_stall;
        cfg_stall7 = st7;
        cfg_seq++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input logic [NCH-1:0] mask, input logic [7:0] info,
                             input logic [7:0] smpr, input bit drop_mid,
                             input bit chk_contig, input bit chk_gap);
        logic [7:0] sum;
        logic [7:0] b;
        int         n;
        int         exp_strobes;
        bit         starved;
        int         big;
        int         odd;
        int         d;

        strobe_log.delete();
        rx_data_cyc.delete();
        sum         = info + smpr;
        exp_strobes = 0;
        starved     = 1'b0;
        push(8'h55, 1'b0, 1'b0);
        push(8'hAA, 1'b0, 1'b0);
        push(info, 1'b0, 1'b0);
        push(smpr, 1'b0, 1'b0);
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch] && !starved) begin
                n = (cfg_avail[ch] < NWORD) ? cfg_avail[ch] : NWORD;
                for (int k = 0; k < n; k++) begin
                    b   = cfg_nxt[ch] + 8'(k);
                    sum = sum + b;
                    push(b, 1'b1, 1'b0);
                end
                exp_strobes += n;
                if (n < NWORD) starved = 1'b1;
            end
        end
`ifdef ADC_PACKER_CHECKSUM_EN
        push(sum, 1'b0, !starved);
`endif
        if (starved) err_sticky = 1'b1;

        check("fd_low_at_start", fd_fifo, 0);
        chn_mask = mask;
        dev_info = info;
        dev_smpr = smpr;
        fs_fifo  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Header fields and mask are latched at start; later changes must not matter.
        chn_mask = NCH'($urandom);
        dev_info = 8'($urandom);
        dev_smpr = 8'($urandom);
        if (drop_mid) begin
            repeat (3) @(negedge clk);
            fs_fifo = 1'b0;
        end

        for (int i = 0; i < 3000; i++) begin
            if (fd_fifo) break;
            @(negedge clk);
        end
        check("fd_fifo_rise", fd_fifo, 1);
        check("err_state", err, err_sticky);
        if (starved && strobe_log.size() > 0)
            check("err_timing", err_rise_cyc, strobe_log[strobe_log.size()-1] + TOUT + 1);

        if (fs_fifo) begin
            repeat (3) @(negedge clk);
            check("fd_fifo_hold", fd_fifo, 1);
            fs_fifo = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            if (!fd_fifo) break;
            @(negedge clk);
        end
        check("fd_fifo_low_idle", fd_fifo, 0);
        repeat (4) @(negedge clk);
        check("bytes_left", exp_q.size(), 0);
        check("strobe_count", strobe_log.size(), exp_strobes);

        if (chk_contig && strobe_log.size() > 0)
            check("strobe_contig", strobe_log[strobe_log.size()-1] - strobe_log[0], exp_strobes - 1);
        if (chk_gap) begin
            big = 0;
            odd = 0;
            for (int i = 1; i < rx_data_cyc.size(); i++) begin
                d = rx_data_cyc[i] - rx_data_cyc[i-1];
                if (d != 1) begin
                    odd++;
                    if (d > big) big = d;
                end
            end
            check("stall_gap", big, 11);
            check("gap_count", odd, 1);
        end
    endtask

    task automatic reset_mid_frame();
        strobe_log.delete();
        push(8'h55, 1'b0, 1'b0);
        push(8'hAA, 1'b0, 1'b0);
        push(8'h5A, 1'b0, 1'b0);
        push(8'hA5, 1'b0, 1'b0);
        for (int k = 0; k < NWORD; k++) push(cfg_nxt[0] + 8'(k), 1'b1, 1'b0);
        chn_mask = 8'hFF;
        dev_info = 8'h5A;
        dev_smpr = 8'hA5;
        fs_fifo  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (strobe_log.size() >= 3) break;
            @(negedge clk);
        end
        check("reached_read", strobe_log.size() >= 3, 1);
        #1 rst = 1'b0;
        #1;
        check("rst_grxen", fifoi_grxen, 0);
        check("rst_rxen", adc_rxen, 0);
        check("rst_rxd", adc_rxd, 0);
        check("rst_fd", fd_fifo, 0);
        check("rst_err", err, 0);
        fs_fifo = 1'b0;
        @(negedge clk);
        exp_q.delete();
        lat_q.delete();
        err_sticky = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("init_fd", fd_fifo, 0);
        check("init_rxen", adc_rxen, 0);
        check("init_rxd", adc_rxd, 0);
        check("init_grxen", fifoi_grxen, 0);
        check("init_err", err, 0);
        rst = 1'b1;
        @(negedge clk);

        // Two channels, never empty, ramp from 0x00.
        set_fifos(1'b0, -1, 1'b0, 1'b0);
        run_frame(8'h03, 8'h12, 8'h34, 1'b0, 1'b1, 1'b0);

        // No channels enabled: header (and sum) only, no strobes.
        set_fifos(1'b1, -1, 1'b0, 1'b0);
        run_frame(8'h00, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);

        // ch7 goes empty for 10 cycles after its second read.
        set_fifos(1'b1, -1, 1'b0, 1'b1);
        run_frame(8'h81, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);

        // Random masks, data and short empty bursts.
        for (int f = 0; f < 6; f++) begin
            set_fifos(1'b1, -1, 1'b1, 1'b0);
            run_frame(NCH'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
        end

        // ch0 runs dry after 2 bytes: timeout, err set.
        set_fifos(1'b1, 2, 1'b0, 1'b0);
        run_frame(8'h05, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);

        // err persists into a normal frame.
        set_fifos(1'b1, -1, 1'b0, 1'b0);
        run_frame(8'h42, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);

        // fs_fifo dropped mid-frame, then a new request after DONE.
        set_fifos(1'b1, -1, 1'b0, 1'b0);
        run_frame(8'h0F, 8'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0);
        set_fifos(1'b1, -1, 1'b0, 1'b0);
        run_frame(8'h30, 8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);

        // Reset in the middle of READ, then a fresh frame.
        set_fifos(1'b1, -1, 1'b0, 1'b0);
        reset_mid_frame();
        set_fifos(1'b1, -1, 1'b0, 1'b0);
        run_frame(8'hA5, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
